// File: rtl/alu_op_sequencer.sv
// Drives operand/opcode codes into a combinational ALU, captures each result and
// streams it downstream; sweep mode folds every accepted result into a signature.
module alu_op_sequencer #(
  parameter int AW = 3,
  parameter int SW = 2,
  parameter int RW = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic                abort,
  input  logic [AW-1:0]       op_a,
  input  logic [AW-1:0]       op_b,
  input  logic [SW-1:0]       op_sel,
  output logic [AW-1:0]       alu_a,
  output logic [AW-1:0]       alu_b,
  output logic [SW-1:0]       alu_sel,
  input  logic [RW-1:0]       alu_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RW-1:0]       out_data,
  output logic [2*AW+SW-1:0]  out_idx,
  output logic                busy,
  output logic                done,
  output logic [RW-1:0]       sig,
  output logic [2:0]          state_dbg
);

  localparam int IW = 2*AW+SW;
  localparam logic [IW-1:0] LAST_IDX = '1;

  // Stream handshake: a result transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid/out_data/out_idx hold until then.
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, OUT, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          single;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      single    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      sig       <= '0;
    end else if (abort && state != IDLE) begin
      // Abort wins over a same-cycle handshake, so nothing is folded into sig.
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= mode ? {op_sel, op_b, op_a} : '0;
            single <= mode;
            sig    <= '0;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          {alu_sel, alu_b, alu_a} <= idx;
          state                   <= SAMPLE;
        end
        SAMPLE: begin
          out_data  <= alu_res;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            sig       <= {sig[RW-2:0], sig[RW-1]} ^ out_data;
            out_valid <= 1'b0;
            // The terminal index ends the run, so idx never wraps.
            if (single || idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= DRIVE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
